// File: rtl/pe_fp_tm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_fp_tm_pkg
// Description : Shared definitions for the time-multiplexed fixed-point PE.
//               Holds the width helpers (product, accumulator, fraction and
//               index widths) and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_fp_tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-precision signed product width.
    function automatic int prod_w(input int fmap_w, input int weight_w);
        return fmap_w + weight_w;
    endfunction

    // Accumulator width: room for every product of a whole position.
    function automatic int acc_w(input int fmap_w, input int weight_w, input int n_terms);
        return fmap_w + weight_w + $clog2(n_terms);
    endfunction

    // Binary point position of products and accumulator.
    function automatic int frac_w(input int fmap_frac, input int weight_frac);
        return fmap_frac + weight_frac;
    endfunction

    // Index/counter width, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_fp_tm_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_fp_tm_if
// Description : Beat/result handshake bundle of pe_fp_tm.
//               slave  : PE side (accepts beats, produces results)
//               master : streamer / writer side
//   in_valid/in_ready   beat handshake
//   fmap_in/weight_in   one depth slice, (fh, fw, channel) packed
//   norm_ref, s         BN threshold integer part and sign
//   out_valid/out_ready result handshake
//   data_out, pindex    binary activation and winning pool index
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_fp_tm_if #(
    parameter int D                 = 512,
    parameter int SLICE_D           = 64,
    parameter int FH                = 3,
    parameter int FW                = 3,
    parameter int POOL_H            = 2,
    parameter int POOL_W            = 2,
    parameter int FMAP_WIDTH        = 16,
    parameter int FMAP_FRAC_WIDTH   = 0,
    parameter int WEIGHT_WIDTH      = 16,
    parameter int WEIGHT_FRAC_WIDTH = 8
);
    localparam int c_lanes = SLICE_D * FH * FW;
    localparam int c_acc_w = pe_fp_tm_pkg::acc_w(FMAP_WIDTH, WEIGHT_WIDTH, D * FH * FW);
    localparam int c_ref_w = c_acc_w - pe_fp_tm_pkg::frac_w(FMAP_FRAC_WIDTH, WEIGHT_FRAC_WIDTH);
    localparam int c_pid_w = pe_fp_tm_pkg::idx_w(POOL_H * POOL_W);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [c_lanes*FMAP_WIDTH-1:0]         fmap_in;
    logic [c_lanes*WEIGHT_WIDTH-1:0]       weight_in;
    logic signed [c_ref_w-1:0]             norm_ref;
    logic                                  s;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  data_out;
    logic [c_pid_w-1:0]                    pindex;

    modport slave (
        input  in_valid, fmap_in, weight_in, norm_ref, s, out_ready,
        output in_ready, out_valid, data_out, pindex
    );

    modport master (
        output in_valid, fmap_in, weight_in, norm_ref, s, out_ready,
        input  in_ready, out_valid, data_out, pindex
    );

endinterface
`default_nettype wire

// File: rtl/pe_fp_mac_slice.sv
`default_nettype none
// ============================================================================
// Module      : pe_fp_mac_slice
// Description : Combinational signed dot product of one depth slice.
//               LANES products are summed by a balanced binary adder tree
//               (padded to a power of two with zero leaves).
//   fmap_in   LANES x FMAP_WIDTH signed values
//   weight_in LANES x WEIGHT_WIDTH signed values (same packing)
//   dot_out   OUT_W signed sum of products
// Revision    : 1.0 - initial release
// ============================================================================
module pe_fp_mac_slice #(
    parameter int  LANES        = 576,
    parameter int  FMAP_WIDTH   = 16,
    parameter int  WEIGHT_WIDTH = 16,
    localparam int OUT_W        = FMAP_WIDTH + WEIGHT_WIDTH + $clog2(LANES)
) (
    input  wire logic [LANES*FMAP_WIDTH-1:0]   fmap_in,
    input  wire logic [LANES*WEIGHT_WIDTH-1:0] weight_in,
    output logic signed [OUT_W-1:0]            dot_out
);
    localparam int c_prod_w = FMAP_WIDTH + WEIGHT_WIDTH;
    localparam int c_np2    = 1 << $clog2(LANES);

    // Heap-ordered tree: node n has children 2n+1 and 2n+2, leaves last.
    logic signed [OUT_W-1:0] w_node [2*c_np2-1];

    for (genvar k = 0; k < c_np2; k++) begin : g_leaf
        if (k < LANES) begin : g_lane
            logic signed [FMAP_WIDTH-1:0]   w_f;
            logic signed [WEIGHT_WIDTH-1:0] w_w;
            logic signed [c_prod_w-1:0]     w_p;
            assign w_f = fmap_in[k*FMAP_WIDTH +: FMAP_WIDTH];
            assign w_w = weight_in[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign w_p = c_prod_w'(w_f) * c_prod_w'(w_w);
            assign w_node[c_np2-1+k] = OUT_W'(w_p);
        end else begin : g_pad
            assign w_node[c_np2-1+k] = '0;
        end
    end

    for (genvar n = 0; n < c_np2 - 1; n++) begin : g_tree
        assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
    end

    assign dot_out = w_node[0];

endmodule
`default_nettype wire

// File: rtl/pe_fp_tm.sv
`default_nettype none
// ============================================================================
// Module      : pe_fp_tm
// Description : Time-multiplexed fixed-point PE. Accumulates the conv output
//               of each pool position over N_SLICE beats, max/min-pools the
//               positions and thresholds the winner into one binary output.
//   clk, rst  clock, asynchronous active-high reset
//   bus       pe_fp_tm_if.slave (beat and result handshakes)
// Option      : PE_FP_TM_PINDEX_EN - track/drive the winning pool index;
//               when undefined pindex is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_fp_tm
    import pe_fp_tm_pkg::*;
#(
    parameter int D                 = 512,
    parameter int SLICE_D           = 64,
    parameter int FH                = 3,
    parameter int FW                = 3,
    parameter int POOL_H            = 2,
    parameter int POOL_W            = 2,
    parameter int FMAP_WIDTH        = 16,
    parameter int FMAP_FRAC_WIDTH   = 0,
    parameter int WEIGHT_WIDTH      = 16,
    parameter int WEIGHT_FRAC_WIDTH = 8
) (
    input wire logic  clk,
    input wire logic  rst,
    pe_fp_tm_if.slave bus
);
    localparam int c_n_slice  = D / SLICE_D;
    localparam int c_n_pos    = POOL_H * POOL_W;
    localparam int c_lanes    = SLICE_D * FH * FW;
    localparam int c_dot_w    = prod_w(FMAP_WIDTH, WEIGHT_WIDTH) + $clog2(c_lanes);
    localparam int c_acc_w    = acc_w(FMAP_WIDTH, WEIGHT_WIDTH, D * FH * FW);
    localparam int c_frac_w   = frac_w(FMAP_FRAC_WIDTH, WEIGHT_FRAC_WIDTH);
    localparam int c_ref_w    = c_acc_w - c_frac_w;
    localparam int c_slice_cw = idx_w(c_n_slice);
    localparam int c_pos_cw   = idx_w(c_n_pos);

    state_t                   r_state, w_state_next;
    logic [c_slice_cw-1:0]    r_slice_cnt;
    logic [c_pos_cw-1:0]      r_pos_cnt;
    logic signed [c_acc_w-1:0] r_acc, r_best;
    logic signed [c_ref_w-1:0] r_norm_ref;
    logic                     r_s, r_data;

    logic                     w_in_ready, w_out_valid, w_accept;
    logic                     w_slice_first, w_slice_last, w_pos_first, w_pos_last;
    logic                     w_first, w_win_last, w_s, w_take, w_data_next;
    logic signed [c_dot_w-1:0] w_dot;
    logic signed [c_acc_w-1:0] w_acc_base, w_sum, w_best_next, w_ref;
    logic signed [c_ref_w-1:0] w_nref;

    pe_fp_mac_slice #(
        .LANES        (c_lanes),
        .FMAP_WIDTH   (FMAP_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_mac (
        .fmap_in   (bus.fmap_in),
        .weight_in (bus.weight_in),
        .dot_out   (w_dot)
    );

    assign w_in_ready    = (r_state != ST_DONE) | bus.out_ready;
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_slice_first = (r_slice_cnt == '0);
    assign w_slice_last  = (r_slice_cnt == c_slice_cw'(c_n_slice - 1));
    assign w_pos_first   = (r_pos_cnt == '0);
    assign w_pos_last    = (r_pos_cnt == c_pos_cw'(c_n_pos - 1));
    assign w_first       = w_slice_first & w_pos_first;
    assign w_win_last    = w_slice_last & w_pos_last;

    // BN controls are latched on the first beat; a one-beat window must use
    // the live values because the latch has not happened yet.
    assign w_s    = w_first ? bus.s : r_s;
    assign w_nref = w_first ? bus.norm_ref : r_norm_ref;

    always_comb begin
        w_acc_base = r_acc;
        if (w_slice_first) begin
            w_acc_base = '0;
        end
        w_sum = w_acc_base + c_acc_w'(w_dot);
        // Strict compare keeps the lowest index on ties.
        w_take = w_pos_first | (w_s ? (w_sum < r_best) : (w_sum > r_best));
        w_best_next = w_take ? w_sum : r_best;
        w_ref = c_acc_w'(w_nref) <<< c_frac_w;
        w_data_next = w_s ? (w_best_next < w_ref) : (w_best_next >= w_ref);
    end

    always_comb begin
        w_state_next = r_state;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACC: begin
                if (w_accept) begin
                    w_state_next = w_win_last ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (w_accept) begin
                    w_state_next = w_win_last ? ST_DONE : ST_ACC;
                end else if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slice_cnt <= '0;
            r_pos_cnt   <= '0;
            r_acc       <= '0;
            r_best      <= '0;
            r_norm_ref  <= '0;
            r_s         <= 1'b0;
            r_data      <= 1'b0;
        end else if (w_accept) begin
            if (w_first) begin
                r_s        <= bus.s;
                r_norm_ref <= bus.norm_ref;
            end
            r_acc <= w_sum;
            if (w_slice_last) begin
                r_slice_cnt <= '0;
                r_best      <= w_best_next;
                r_pos_cnt   <= w_pos_last ? '0 : r_pos_cnt + c_pos_cw'(1);
            end else begin
                r_slice_cnt <= r_slice_cnt + c_slice_cw'(1);
            end
            if (w_win_last) begin
                r_data <= w_data_next;
            end
        end
    end

`ifdef PE_FP_TM_PINDEX_EN
    logic [c_pos_cw-1:0] r_bidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bidx <= '0;
        end else if (w_accept && w_slice_last && w_take) begin
            r_bidx <= r_pos_cnt;
        end
    end

    assign bus.pindex = r_bidx;
`else
    assign bus.pindex = '0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.data_out  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_pe_fp_tm.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_fp_tm
// Description : Directed testbench for pe_fp_tm. A small instance (D=4,
//               SLICE_D=2, 1x1 filter, 2x2 pool) covers pooling, threshold,
//               back-pressure and reset; a default-parameter instance covers
//               the full-range accumulation.
//               Small instance encoding: weights are 1.0 (256) and 2.0 (512),
//               slice 0 fmaps (4,-1) give 2.0, slice 1 fmaps (S-4,1) give
//               S-2.0, so each position sums to exactly S.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_fp_tm;

    logic clk = 1'b0;
    logic rst;
    int   n_total;
    int   n_bad;

    always #5 clk = ~clk;

    pe_fp_tm_if #(.D(4), .SLICE_D(2), .FH(1), .FW(1), .POOL_H(2), .POOL_W(2)) bs ();
    pe_fp_tm #(.D(4), .SLICE_D(2), .FH(1), .FW(1), .POOL_H(2), .POOL_W(2)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs.slave)
    );

    pe_fp_tm_if bd ();
    pe_fp_tm u_dut_d (
        .clk (clk),
        .rst (rst),
        .bus (bd.slave)
    );

    // 32768*32767*4608 / 256 = 32768*32767*18
    localparam longint c_def_nref = -64'sd19326763008;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint exp_pidx(input int p);
`ifdef PE_FP_TM_PINDEX_EN
        return longint'(p);
`else
        return 0 * longint'(p);
`endif
    endfunction

    task automatic drive_small(input int sum, input int sl, input logic sv, input int nref);
        logic signed [15:0] f0, f1;
        f0 = (sl == 0) ? 16'sd4 : 16'(sum - 4);
        f1 = (sl == 0) ? -16'sd1 : 16'sd1;
        bs.fmap_in   = {f1, f0};
        bs.weight_in = {16'sd512, 16'sd256};
        bs.s         = sv;
        bs.norm_ref  = 26'(nref);
        bs.in_valid  = 1'b1;
    endtask

    // Sends n_beats beats of a window; BN controls are valid only on the
    // first beat and deliberately corrupted on the others.
    task automatic send_small(input int sums[4], input logic sv, input int nref, input int n_beats);
        int b;
        b = 0;
        for (int p = 0; p < 4; p++) begin
            for (int sl = 0; sl < 2; sl++) begin
                if (b < n_beats) begin
                    if (b == 0) drive_small(sums[p], sl, sv, nref);
                    else        drive_small(sums[p], sl, ~sv, nref + 100);
                    @(negedge clk);
                    check_eq("in_ready", longint'(bs.in_ready), 1);
                    if (b == 7) check_eq("valid before last", longint'(bs.out_valid), 0);
                    @(posedge clk);
                    #1;
                    if (b == 0) begin
                        bs.out_ready = 1'b0;
                        check_eq("valid after first", longint'(bs.out_valid), 0);
                    end
                    b++;
                end
            end
        end
        bs.in_valid = 1'b0;
    endtask

    task automatic expect_small(input string tag, input logic exp_data, input int exp_p);
        check_eq({tag, " valid"}, longint'(bs.out_valid), 1);
        check_eq({tag, " data"}, longint'(bs.data_out), longint'(exp_data));
        check_eq({tag, " pindex"}, longint'(bs.pindex), exp_pidx(exp_p));
    endtask

    task automatic retire_small();
        bs.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bs.out_ready = 1'b0;
        check_eq("retired valid", longint'(bs.out_valid), 0);
    endtask

    task automatic run_default(input string tag, input longint nref, input logic exp_data);
        bd.norm_ref = 37'(nref);
        bd.s        = 1'b0;
        bd.in_valid = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        bd.in_valid = 1'b0;
        check_eq({tag, " valid"}, longint'(bd.out_valid), 1);
        check_eq({tag, " data"}, longint'(bd.data_out), longint'(exp_data));
        check_eq({tag, " pindex"}, longint'(bd.pindex), 0);
        bd.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bd.out_ready = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bs.in_valid  = 1'b0;
        bs.out_ready = 1'b0;
        bs.fmap_in   = '0;
        bs.weight_in = '0;
        bs.norm_ref  = '0;
        bs.s         = 1'b0;
        bd.in_valid  = 1'b0;
        bd.out_ready = 1'b0;
        bd.fmap_in   = {576{16'h8000}};
        bd.weight_in = {576{16'h7fff}};
        bd.norm_ref  = '0;
        bd.s         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset in_ready", longint'(bs.in_ready), 1);
        check_eq("reset out_valid", longint'(bs.out_valid), 0);
        check_eq("reset data", longint'(bs.data_out), 0);
        check_eq("reset pindex", longint'(bs.pindex), 0);

        // Max pool, tie on 7 keeps position 1.
        send_small('{3, 7, 5, 7}, 1'b0, 6, 8);
        expect_small("A max", 1'b1, 1);

        // Back-pressure: junk beats offered while the result is held.
        drive_small(100, 0, 1'b1, -5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("hold in_ready", longint'(bs.in_ready), 0);
            expect_small("hold", 1'b1, 1);
        end
        @(posedge clk);
        #1;

        // Retire and take the next first beat on the same edge.
        bs.out_ready = 1'b1;
        send_small('{3, 7, 5, 7}, 1'b1, 4, 8);
        expect_small("B min", 1'b1, 0);
        retire_small();
        check_eq("idle in_ready", longint'(bs.in_ready), 1);

        send_small('{3, 7, 5, 7}, 1'b1, 3, 8);
        expect_small("C min eq ref", 1'b0, 0);
        retire_small();

        send_small('{6, 6, 6, 6}, 1'b0, 6, 8);
        expect_small("D tie max", 1'b1, 0);
        retire_small();

        send_small('{6, 6, 6, 6}, 1'b1, 6, 8);
        expect_small("E tie min", 1'b0, 0);
        retire_small();

        send_small('{1, 2, 9, 4}, 1'b0, 0, 8);
        expect_small("F max", 1'b1, 2);
        retire_small();

        // Abort a window after three beats.
        send_small('{50, 60, 70, 80}, 1'b1, 90, 3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst out_valid", longint'(bs.out_valid), 0);
        check_eq("rst data", longint'(bs.data_out), 0);
        check_eq("rst pindex", longint'(bs.pindex), 0);
        check_eq("rst in_ready", longint'(bs.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_small('{1, 2, 3, 4}, 1'b0, 0, 8);
        expect_small("H after rst", 1'b1, 3);
        retire_small();

        // Full-range accumulation on the default configuration.
        run_default("def exact", c_def_nref, 1'b1);
        run_default("def above", c_def_nref + 1, 1'b0);
        run_default("def min", -(64'sd1 <<< 36), 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
